// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-to-decode queue.
// The entry struct is sized by the package localparams, which match the fetch_queue defaults.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake bundle for fetch_queue.
// Signals:
//   push_valid_i, instr_i, pc_i, pc_plus4_i, flush_i, stall_i are driven by the master (fetch/decode side).
//   push_ready_o, validD_o, instrD_o, pcD_o, pc_plus4D_o, count_o are driven by the slave (the queue).
interface fetch_queue_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
);
  logic push_valid_i;
  logic push_ready_o;
  logic [INSTR_WIDTH-1:0] instr_i;
  logic [DATA_WIDTH-1:0] pc_i;
  logic [DATA_WIDTH-1:0] pc_plus4_i;
  logic flush_i;
  logic stall_i;
  logic validD_o;
  logic [INSTR_WIDTH-1:0] instrD_o;
  logic [DATA_WIDTH-1:0] pcD_o;
  logic [DATA_WIDTH-1:0] pc_plus4D_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  modport master (
    output push_valid_i, instr_i, pc_i, pc_plus4_i, flush_i, stall_i,
    input push_ready_o, validD_o, instrD_o, pcD_o, pc_plus4D_o, count_o
  );
  modport slave (
    input push_valid_i, instr_i, pc_i, pc_plus4_i, flush_i, stall_i,
    output push_ready_o, validD_o, instrD_o, pcD_o, pc_plus4D_o, count_o
  );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: pointer, occupancy and handshake control for fetch_queue.
// Ports: clk, rst (async, active-high); push_valid, flush, stall in;
//   push_ready, valid, byp (input forwarded straight to decode), push (write enable),
//   wr_ptr, rd_ptr, count out.
// Optional macro FETCH_QUEUE_BYPASS_EN enables same-cycle forwarding into an empty queue.
module fetch_queue_ctrl #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input logic clk,
  input logic rst,
  input logic push_valid,
  input logic flush,
  input logic stall,
  output logic push_ready,
  output logic valid,
  output logic byp,
  output logic push,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count
);
  logic full, empty, pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ready = !full;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & push_valid & !flush;
`else
  assign byp = 1'b0;
`endif
  assign valid = !empty | byp;
  // a forwarded entry consumed by decode in the same cycle is never written
  assign push = push_valid & !full & !flush & !(byp & !stall);
  assign pop = !empty & !stall & !flush;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry show-ahead instruction FIFO between fetch and decode.
// Ports: clk, rst (async, active-high); bus (fetch_queue_if.slave) carrying the push
//   handshake, flush/stall and the decode-side head outputs plus occupancy count.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the incoming entry to decode
//   combinationally; otherwise every entry spends at least one cycle in storage.
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave bus
);
  import fetch_pkg::*;
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, valid, byp;
  fetch_entry_t mem [DEPTH];
  fetch_entry_t in_e, head;
  fetch_queue_ctrl #(.DEPTH(DEPTH)) ctrl (
    .clk(clk),
    .rst(rst),
    .push_valid(bus.push_valid_i),
    .flush(bus.flush_i),
    .stall(bus.stall_i),
    .push_ready(bus.push_ready_o),
    .valid(valid),
    .byp(byp),
    .push(push),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(bus.count_o)
  );
  assign in_e = '{instr: bus.instr_i, pc: bus.pc_i, pc_plus4: bus.pc_plus4_i};
  // storage is left uncleared on reset; valid masks stale contents
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_e;
  assign head = byp ? in_e : mem[rd_ptr];
  assign bus.validD_o = valid;
  assign bus.instrD_o = valid ? head.instr : NOP_INSTR;
  assign bus.pcD_o = valid ? head.pc : '0;
  assign bus.pc_plus4D_o = valid ? head.pc_plus4 : '0;
endmodule
